// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants and types for the pipelined 64-bit carry-lookahead adder.
//   WIDTH   : operand width (64)
//   GROUP   : bits per lookahead group (4)
//   NGROUPS : number of lookahead groups (16)
//   s1_t    : contents of the stage-1 pipeline register
//   group_pg: folds four bit-level p/g pairs into one group {G, P}
package alu_pkg;

    localparam int WIDTH   = 64;
    localparam int GROUP   = 4;
    localparam int NGROUPS = WIDTH / GROUP;

    typedef struct packed {
        logic [WIDTH-1:0]   x;     // a ^ b' per bit (sum before the carry is applied)
        logic [WIDTH-1:0]   p;     // bit propagate
        logic [WIDTH-1:0]   g;     // bit generate
        logic [NGROUPS-1:0] gp;    // group propagate
        logic [NGROUPS-1:0] gg;    // group generate
        logic               cin;   // carry into bit 0 (1 for subtract)
        logic               word;  // 32-bit operation
    } s1_t;

    // Returns {G, P} for one 4-bit group.
    function automatic logic [1:0] group_pg(input logic [3:0] p, input logic [3:0] g);
        logic gen;
        logic prop;
        gen  = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        prop = &p;
        return {gen, prop};
    endfunction

endpackage

// File: rtl/cla_carry_unit16.sv
// cla_carry_unit16
// Combinational lookahead carry unit for 16 groups.
// Every group carry is formed directly from the group P/G terms and the
// carry-in as a flat sum of products, so no carry ripples from one group
// to the next:
//   C[j+1] = G[j] | P[j]G[j-1] | ... | P[j]..P[1]G[0] | P[j]..P[0]cin
//   gp  : group propagate, one per group
//   gg  : group generate, one per group
//   cin : carry into group 0
//   c   : c[j] is the carry into group j; c[16] is the carry out of the top group
module cla_carry_unit16 import alu_pkg::*; (
    input  logic [NGROUPS-1:0] gp,
    input  logic [NGROUPS-1:0] gg,
    input  logic               cin,
    output logic [NGROUPS:0]   c
);

    logic sop;
    logic term;

    always_comb begin
        c    = '0;
        sop  = 1'b0;
        term = 1'b0;
        c[0] = cin;
        for (int j = 0; j < NGROUPS; j++) begin
            // Carry-in term propagated through groups 0..j.
            sop = cin;
            for (int i = 0; i <= j; i++) begin
                sop = sop & gp[i];
            end
            // Generate of group i propagated through groups i+1..j.
            for (int i = 0; i <= j; i++) begin
                term = gg[i];
                for (int k = i + 1; k <= j; k++) begin
                    term = term & gp[k];
                end
                sop = sop | term;
            end
            c[j+1] = sop;
        end
    end

endmodule

// File: rtl/pfa_cell.sv
// pfa_cell
// Partial full adder: the per-bit cell of the integer ALU datapath.
// Produces the bit sum together with the propagate and generate terms
// consumed by the lookahead carry logic.
//   a, b : operand bits
//   c    : carry into this bit
//   s    : a ^ b ^ c
//   p    : a | b (propagate)
//   g    : a & b (generate)
module pfa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic p,
    output logic g
);

    assign s = a ^ b ^ c;
    assign p = a | b;
    assign g = a & b;

endmodule

// File: rtl/cla_pipe_adder64b.sv
// cla_pipe_adder64b
// Two-stage pipelined 64-bit carry-lookahead adder/subtractor with
// RV64 word-op (ADDW/SUBW) support.
//   Stage 1: conditional inversion of b, per-bit p/g/xor from the partial
//            full adder cells, and the 16 group P/G terms.
//   Stage 2: lookahead group carries, bit carries inside each group, then
//            sum, carry out, signed overflow and zero flag.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : kills every in-flight op and the op presented this cycle
//   in_valid / in_ready : operand handshake
//   a, b, sub, word     : operands; sub selects a-b, word selects a 32-bit op
//   out_valid/out_ready : result handshake
//   s, c_o, ovf, zero   : result, carry out (1 = no borrow on subtract),
//                         signed overflow, result-is-zero
module cla_pipe_adder64b #(
    parameter int WIDTH = 64,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_o,
    output logic             ovf,
    output logic             zero
);

    import alu_pkg::*;

    localparam int NG = WIDTH / GROUP;

    // Control
    logic vld_p1;
    logic vld_p2;
    logic s2_ready;
    logic accept;
    logic advance;

    // Stage-1 combinational terms
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] x_c;
    logic [WIDTH-1:0] p_c;
    logic [WIDTH-1:0] g_c;
    logic [NG-1:0]    gp_c;
    logic [NG-1:0]    gg_c;

    // Stage-1 register
    s1_t s1_p1;

    // Stage-2 combinational terms
    logic [NG:0]      gc;
    logic [WIDTH:0]   c_bit;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] s_c;
    logic             c_o_c;
    logic             ovf_c;
    logic             zero_c;

    // Stage-2 registers
    logic [WIDTH-1:0] s_p2;
    logic             c_o_p2;
    logic             ovf_p2;
    logic             zero_p2;

    // An empty stage always accepts, so bubbles collapse under a stall.
    assign s2_ready = !vld_p2 || out_ready;
    assign in_ready = rst_n && !flush && (!vld_p1 || s2_ready);
    assign accept   = in_valid && in_ready;
    assign advance  = vld_p1 && s2_ready && !flush;

    // ---------------------------------------------------------------- stage 1
    assign b_eff = b ^ {WIDTH{sub}};

    // The cells run with a zero carry so their sum output is a ^ b'; the
    // real carry is folded in during stage 2.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pfa_cell u_pfa (
            .a (a[i]),
            .b (b_eff[i]),
            .c (1'b0),
            .s (x_c[i]),
            .p (p_c[i]),
            .g (g_c[i])
        );
    end

    for (genvar j = 0; j < NG; j++) begin : g_grp
        assign {gg_c[j], gp_c[j]} = group_pg(p_c[GROUP*j +: GROUP], g_c[GROUP*j +: GROUP]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            s1_p1  <= '0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (accept) begin
                s1_p1.x    <= x_c;
                s1_p1.p    <= p_c;
                s1_p1.g    <= g_c;
                s1_p1.gp   <= gp_c;
                s1_p1.gg   <= gg_c;
                s1_p1.cin  <= sub;
                s1_p1.word <= word;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    cla_carry_unit16 u_carry (
        .gp  (s1_p1.gp),
        .gg  (s1_p1.gg),
        .cin (s1_p1.cin),
        .c   (gc)
    );

    // Group carries seed the first bit of each group; the remaining three
    // bits of the group ripple locally from that seed.
    always_comb begin
        c_bit = '0;
        for (int j = 0; j < NG; j++) begin
            c_bit[j*GROUP] = gc[j];
            for (int k = 1; k < GROUP; k++) begin
                c_bit[j*GROUP+k] = s1_p1.g[j*GROUP+k-1]
                                 | (s1_p1.p[j*GROUP+k-1] & c_bit[j*GROUP+k-1]);
            end
        end
        c_bit[WIDTH] = gc[NG];
    end

    // Word ops take carries from bit 31/32 only; the upper half of the sum
    // is replaced by the sign of bit 31, so upper-half carries are ignored.
    always_comb begin
        sum_c = s1_p1.x ^ c_bit[WIDTH-1:0];
        if (s1_p1.word) begin
            s_c   = {{(WIDTH-32){sum_c[31]}}, sum_c[31:0]};
            c_o_c = c_bit[32];
            ovf_c = c_bit[31] ^ c_bit[32];
        end else begin
            s_c   = sum_c;
            c_o_c = c_bit[WIDTH];
            ovf_c = c_bit[WIDTH-1] ^ c_bit[WIDTH];
        end
        zero_c = (s_c == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            s_p2    <= '0;
            c_o_p2  <= 1'b0;
            ovf_p2  <= 1'b0;
            zero_p2 <= 1'b0;
        end else begin
            if (flush) begin
                vld_p2 <= 1'b0;
            end else if (s2_ready) begin
                vld_p2 <= vld_p1;
            end
            if (advance) begin
                s_p2    <= s_c;
                c_o_p2  <= c_o_c;
                ovf_p2  <= ovf_c;
                zero_p2 <= zero_c;
            end
        end
    end

    assign out_valid = vld_p2;
    assign s         = s_p2;
    assign c_o       = c_o_p2;
    assign ovf       = ovf_p2;
    assign zero      = zero_p2;

endmodule
